// File: rtl/timer_unit_if.sv
// Data-bus view of the timer register window: CPU-side address/store lanes in,
// combinational read data out.
interface timer_unit_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output byteen, input rdata);
  modport slave  (input addr, input wdata, input byteen, output rdata);
endinterface

// File: rtl/timer_unit.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes; raises a
// registered interrupt request when the count expires.
module timer_unit #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic         clk,
  input  logic         reset,
  timer_unit_if.slave  bus,
  output logic         irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  localparam logic [29:0] BASE_WORD = BASE[31:2];

  state_t      state, state_n;
  logic        en, en_n;
  logic [1:0]  mode, mode_n;
  logic        im, im_n;
  logic [31:0] preset, preset_n;
  logic [31:0] count, count_n;
  logic        irq_flag, irq_flag_n;
  logic        irq_n;

  logic [29:0] word;
  logic        sel_ctrl, sel_preset, sel_count;
  logic        ctrl_wr, preset_wr;
  logic        addr_lsb_unused;

  // Byte offset bits inside a word play no part in decoding.
  assign word            = bus.addr[31:2];
  assign addr_lsb_unused = ^bus.addr[1:0];
  assign sel_ctrl        = (word == BASE_WORD);
  assign sel_preset      = (word == BASE_WORD + 30'd1);
  assign sel_count       = (word == BASE_WORD + 30'd2);
  assign ctrl_wr         = sel_ctrl & bus.byteen[0];
  assign preset_wr       = sel_preset & (|bus.byteen);

  always_comb begin
    bus.rdata = 32'h0;
    if (sel_ctrl)
      bus.rdata = {28'h0, im, mode, en};
    else if (sel_preset)
      bus.rdata = preset;
    else if (sel_count)
      bus.rdata = count;
  end

  always_comb begin
    state_n    = state;
    en_n       = en;
    mode_n     = mode;
    im_n       = im;
    preset_n   = preset;
    count_n    = count;
    irq_flag_n = irq_flag;

    case (state)
      IDLE: begin
        if (en)
          state_n = LOAD;
      end
      LOAD: begin
        count_n = preset;
        state_n = CNT;
      end
      CNT: begin
        if (!en) begin
          state_n = IDLE;
        end else if (count > 32'd1) begin
          count_n = count - 32'd1;
        end else begin
          count_n    = 32'h0;
          irq_flag_n = 1'b1;
          state_n    = INT;
        end
      end
      INT: begin
        if (mode == 2'b01) begin
          irq_flag_n = 1'b0;
          state_n    = LOAD;
        end else begin
          en_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Bus writes are applied after the FSM so a CTRL store overrides the
    // one-shot EN clear, and any register store acknowledges the interrupt.
    if (ctrl_wr) begin
      en_n   = bus.wdata[0];
      mode_n = bus.wdata[2:1];
      im_n   = bus.wdata[3];
    end
    if (preset_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byteen[b])
          preset_n[8*b +: 8] = bus.wdata[8*b +: 8];
      end
    end
    if (ctrl_wr || preset_wr)
      irq_flag_n = 1'b0;

    irq_n = irq_flag_n & im_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      en       <= 1'b0;
      mode     <= 2'b00;
      im       <= 1'b0;
      preset   <= 32'h0;
      count    <= 32'h0;
      irq_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state    <= state_n;
      en       <= en_n;
      mode     <= mode_n;
      im       <= im_n;
      preset   <= preset_n;
      count    <= count_n;
      irq_flag <= irq_flag_n;
      irq      <= irq_n;
    end
  end

endmodule
